// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between the processor core and the program loader.
// One access at a time: a write takes IDLE->GNT->IDLE, a read takes
// IDLE->GNT->RESP->IDLE. Ties alternate owners unless the loader holds the
// bus lock. Memory read data arrives one cycle after the address.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | no access in flight; requests are arbitrated here
//  GNT_C  | core owns the memory port for one cycle
//  GNT_L  | loader owns the memory port for one cycle
//  RESP_C | memory read data for the core is on mem_rdata
//  RESP_L | memory read data for the loader is on mem_rdata
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic          ld_lock,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          core_stall,
    output logic [15:0]   conflict_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GNT_C  = 3'd1,
        GNT_L  = 3'd2,
        RESP_C = 3'd3,
        RESP_L = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_ld;      // 1: loader was the most recent owner
    logic          last_ld_nxt;
    logic          tie;
    logic [15:0]   conflict_q;
    logic [DW-1:0] core_rdata_q;
    logic [DW-1:0] ld_rdata_q;

    // State and last-owner registers; reset hands the first tie to the core.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= IDLE;
            last_ld <= 1'b1;
        end else begin
            state   <= state_nxt;
            last_ld <= last_ld_nxt;
        end
    end

    // Next-state decode: arbitration in IDLE, fixed sequencing elsewhere.
    always_comb begin
        state_nxt   = state;
        last_ld_nxt = last_ld;
        tie         = 1'b0;
        case (state)
            IDLE: begin
                tie = core_req && ld_req;
                if (core_req && ld_req) begin
                    // Lock wins outright; otherwise the previous non-owner wins.
                    if (ld_lock || !last_ld) state_nxt = GNT_L;
                    else                     state_nxt = GNT_C;
                end else if (ld_req) begin
                    state_nxt = GNT_L;
                end else if (core_req && !ld_lock) begin
                    state_nxt = GNT_C;
                end
            end
            GNT_C: begin
                last_ld_nxt = 1'b0;
                state_nxt   = core_we ? IDLE : RESP_C;
            end
            GNT_L: begin
                last_ld_nxt = 1'b1;
                state_nxt   = ld_we ? IDLE : RESP_L;
            end
            RESP_C:  state_nxt = IDLE;
            RESP_L:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port is driven only by the current owner; idle value is all zero.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (state == GNT_C) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_we    = core_we;
        end else if (state == GNT_L) begin
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            mem_we    = ld_we;
        end
    end

    // Saturating tie counter.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            conflict_q <= '0;
        end else if (tie && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    // Read data is captured as the response cycle ends and held afterwards.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            core_rdata_q <= '0;
            ld_rdata_q   <= '0;
        end else begin
            if (state == RESP_C) core_rdata_q <= mem_rdata;
            if (state == RESP_L) ld_rdata_q   <= mem_rdata;
        end
    end

    assign core_gnt     = (state == GNT_C);
    assign ld_gnt       = (state == GNT_L);
    assign core_rvalid  = (state == RESP_C);
    assign ld_rvalid    = (state == RESP_L);
    // During the response cycle the live memory data is passed straight through.
    assign core_rdata   = (state == RESP_C) ? mem_rdata : core_rdata_q;
    assign ld_rdata     = (state == RESP_L) ? mem_rdata : ld_rdata_q;
    assign core_stall   = core_req && (state != GNT_C);
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory model.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          clr;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          ld_req, ld_we, ld_lock;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt, ld_rvalid;
    logic [DW-1:0] ld_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          core_stall;
    logic [15:0]   conflict_cnt;

    int vecs = 0;
    int errs = 0;

    logic [DW-1:0] mem [0:255];

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .clr(clr),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
        .ld_rdata(ld_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .core_stall(core_stall), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous memory: write on the edge, read data one cycle later.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        ld_req = 0; ld_we = 0; ld_lock = 0; ld_addr = '0; ld_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        @(negedge clk);
        clr = 0;
        #1;
        vecs++; if ({core_gnt, ld_gnt, core_rvalid, ld_rvalid, mem_we} !== 5'b0) begin
            errs++; $display("FAIL rst_ctl: got %b want 00000", {core_gnt, ld_gnt, core_rvalid, ld_rvalid, mem_we}); end
        vecs++; if (mem_addr !== '0) begin errs++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        vecs++; if (conflict_cnt !== 16'h0) begin errs++; $display("FAIL rst_cnt: got %h want 0", conflict_cnt); end
        vecs++; if ({core_rdata, ld_rdata} !== '0) begin
            errs++; $display("FAIL rst_rdata: got %h/%h want 0/0", core_rdata, ld_rdata); end
        repeat (2) @(negedge clk);
        clr = 1;
        @(negedge clk);
        vecs++; if ({core_gnt, ld_gnt, mem_we} !== 3'b0) begin
            errs++; $display("FAIL rst_after: got %b want 000", {core_gnt, ld_gnt, mem_we}); end
    endtask

    task automatic test_loader_write();
        cyc(); ld_req = 1; ld_we = 1; ld_addr = 32'h4; ld_wdata = 32'h13;
        @(negedge clk);
        vecs++; if (ld_gnt !== 1'b0) begin errs++; $display("FAIL ldw_c0_gnt: got %b want 0", ld_gnt); end
        cyc(); @(negedge clk);
        vecs++; if (ld_gnt !== 1'b1 || core_gnt !== 1'b0) begin
            errs++; $display("FAIL ldw_gnt: got ld=%b core=%b want 1/0", ld_gnt, core_gnt); end
        vecs++; if (mem_we !== 1'b1 || mem_wdata !== 32'h13 || mem_addr !== 32'h4) begin
            errs++; $display("FAIL ldw_mem: got we=%b d=%h a=%h want 1/13/4", mem_we, mem_wdata, mem_addr); end
        cyc(); idle_inputs(); @(negedge clk);
        vecs++; if ({ld_gnt, ld_rvalid, mem_we} !== 3'b0) begin
            errs++; $display("FAIL ldw_c2: got %b want 000", {ld_gnt, ld_rvalid, mem_we}); end
        cyc(); @(negedge clk);
        vecs++; if (ld_rvalid !== 1'b0) begin errs++; $display("FAIL ldw_norvalid: got %b want 0", ld_rvalid); end
    endtask

    task automatic test_core_write();
        cyc(); core_req = 1; core_we = 1; core_addr = 32'h10; core_wdata = 32'hDEADBEEF;
        @(negedge clk);
        vecs++; if (core_stall !== 1'b1) begin errs++; $display("FAIL cw_stall0: got %b want 1", core_stall); end
        cyc(); @(negedge clk);
        vecs++; if (core_gnt !== 1'b1 || core_stall !== 1'b0) begin
            errs++; $display("FAIL cw_gnt: got gnt=%b stall=%b want 1/0", core_gnt, core_stall); end
        vecs++; if (mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h10) begin
            errs++; $display("FAIL cw_mem: got we=%b d=%h a=%h want 1/deadbeef/10", mem_we, mem_wdata, mem_addr); end
        cyc(); idle_inputs(); @(negedge clk);
        vecs++; if ({core_gnt, core_rvalid, mem_we} !== 3'b0) begin
            errs++; $display("FAIL cw_done: got %b want 000", {core_gnt, core_rvalid, mem_we}); end
    endtask

    task automatic test_core_read();
        cyc(); core_req = 1; core_we = 0; core_addr = 32'h10;
        @(negedge clk);
        vecs++; if (core_stall !== 1'b1 || core_gnt !== 1'b0) begin
            errs++; $display("FAIL cr_c0: got stall=%b gnt=%b want 1/0", core_stall, core_gnt); end
        cyc(); @(negedge clk);
        vecs++; if (core_gnt !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || core_stall !== 1'b0) begin
            errs++; $display("FAIL cr_c1: got gnt=%b a=%h we=%b stall=%b want 1/10/0/0", core_gnt, mem_addr, mem_we, core_stall); end
        cyc(); idle_inputs(); @(negedge clk);
        vecs++; if (core_rvalid !== 1'b1 || core_rdata !== 32'hDEADBEEF) begin
            errs++; $display("FAIL cr_c2: got rv=%b d=%h want 1/deadbeef", core_rvalid, core_rdata); end
        vecs++; if (core_stall !== 1'b0 || ld_rvalid !== 1'b0) begin
            errs++; $display("FAIL cr_c2_misc: got stall=%b ldrv=%b want 0/0", core_stall, ld_rvalid); end
        cyc(); @(negedge clk);
        vecs++; if (core_rvalid !== 1'b0 || core_rdata !== 32'hDEADBEEF) begin
            errs++; $display("FAIL cr_hold: got rv=%b d=%h want 0/deadbeef", core_rvalid, core_rdata); end
    endtask

    task automatic test_loader_read();
        cyc(); ld_req = 1; ld_we = 0; ld_addr = 32'h4;
        cyc(); @(negedge clk);
        vecs++; if (ld_gnt !== 1'b1 || mem_addr !== 32'h4) begin
            errs++; $display("FAIL lr_gnt: got gnt=%b a=%h want 1/4", ld_gnt, mem_addr); end
        cyc(); idle_inputs(); @(negedge clk);
        vecs++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'h13 || core_rvalid !== 1'b0) begin
            errs++; $display("FAIL lr_data: got rv=%b d=%h crv=%b want 1/13/0", ld_rvalid, ld_rdata, core_rvalid); end
        cyc(); @(negedge clk);
        vecs++; if (ld_rdata !== 32'h13 || core_rdata !== 32'hDEADBEEF) begin
            errs++; $display("FAIL lr_hold: got ld=%h core=%h want 13/deadbeef", ld_rdata, core_rdata); end
    endtask

    task automatic test_tie();
        int n;
        logic want_core;
        n = 0;
        cyc(); core_req = 1; ld_req = 1; core_addr = 32'h10; ld_addr = 32'h4;
        for (int i = 0; i < 30 && n < 4; i++) begin
            @(negedge clk);
            vecs++; if ((core_gnt && ld_gnt) || (core_rvalid && ld_rvalid)) begin
                errs++; $display("FAIL tie_excl: got gnt=%b%b rv=%b%b want one-hot", core_gnt, ld_gnt, core_rvalid, ld_rvalid); end
            if (core_gnt || ld_gnt) begin
                want_core = (n % 2 == 0);
                vecs++; if (core_gnt !== want_core) begin
                    errs++; $display("FAIL tie_order%0d: got core_gnt=%b want %b", n, core_gnt, want_core); end
                vecs++; if (conflict_cnt !== 16'(n + 1)) begin
                    errs++; $display("FAIL tie_cnt%0d: got %0d want %0d", n, conflict_cnt, n + 1); end
                n++;
            end
        end
        vecs++; if (n != 4) begin errs++; $display("FAIL tie_timeout: got %0d grants want 4", n); end
        cyc(); idle_inputs();
        repeat (2) cyc();
    endtask

    task automatic test_lock();
        int lg;
        lg = 0;
        cyc(); core_req = 1; ld_lock = 1; core_addr = 32'h10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vecs++; if (core_gnt !== 1'b0 || core_stall !== 1'b1) begin
                errs++; $display("FAIL lock_core_only: got gnt=%b stall=%b want 0/1", core_gnt, core_stall); end
        end
        cyc(); ld_req = 1; ld_addr = 32'h4;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vecs++; if (core_gnt !== 1'b0 || core_stall !== 1'b1) begin
                errs++; $display("FAIL lock_both: got gnt=%b stall=%b want 0/1", core_gnt, core_stall); end
            if (ld_gnt) lg++;
        end
        vecs++; if (lg != 4) begin errs++; $display("FAIL lock_ldgnts: got %0d want 4", lg); end
        cyc(); ld_lock = 0;
        @(negedge clk);
        vecs++; if (core_gnt !== 1'b0 || ld_gnt !== 1'b0) begin
            errs++; $display("FAIL unlock_idle: got %b%b want 00", core_gnt, ld_gnt); end
        cyc(); @(negedge clk);
        vecs++; if (core_gnt !== 1'b1) begin errs++; $display("FAIL unlock_core: got %b want 1", core_gnt); end
        cyc(); idle_inputs();
        repeat (2) cyc();
    endtask

    task automatic test_lock_during_core();
        cyc(); core_req = 1; core_we = 0; core_addr = 32'h10;
        cyc(); @(negedge clk);
        vecs++; if (core_gnt !== 1'b1) begin errs++; $display("FAIL lk_core_gnt: got %b want 1", core_gnt); end
        cyc(); ld_lock = 1; ld_req = 1; ld_we = 0; ld_addr = 32'h4;
        @(negedge clk);
        vecs++; if (core_rvalid !== 1'b1 || core_rdata !== 32'hDEADBEEF) begin
            errs++; $display("FAIL lk_core_rv: got rv=%b d=%h want 1/deadbeef", core_rvalid, core_rdata); end
        cyc(); @(negedge clk);
        vecs++; if (core_gnt !== 1'b0 || ld_gnt !== 1'b0) begin
            errs++; $display("FAIL lk_idle: got %b%b want 00", core_gnt, ld_gnt); end
        cyc(); @(negedge clk);
        vecs++; if (ld_gnt !== 1'b1 || core_gnt !== 1'b0) begin
            errs++; $display("FAIL lk_ld_gnt: got ld=%b core=%b want 1/0", ld_gnt, core_gnt); end
        cyc(); idle_inputs();
        repeat (2) cyc();
    endtask

    task automatic test_withdraw();
        cyc(); ld_req = 1; ld_we = 0; ld_addr = 32'h4;
        cyc(); @(negedge clk);
        vecs++; if (ld_gnt !== 1'b1) begin errs++; $display("FAIL wd_ldgnt: got %b want 1", ld_gnt); end
        cyc(); ld_req = 0; core_req = 1; core_addr = 32'h10;
        @(negedge clk);
        vecs++; if (core_stall !== 1'b1 || ld_rvalid !== 1'b1) begin
            errs++; $display("FAIL wd_resp: got stall=%b rv=%b want 1/1", core_stall, ld_rvalid); end
        cyc(); core_req = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vecs++; if (core_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0) begin
                errs++; $display("FAIL wd_nogrant: got gnt=%b we=%b a=%h want 0/0/0", core_gnt, mem_we, mem_addr); end
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        logic [15:0] exp;
        // Preset the counter just below its ceiling, then tie under lock.
        @(negedge clk);
        force dut.conflict_q = 16'hFFFC;
        #1;
        release dut.conflict_q;
        exp = 16'hFFFC;
        cyc(); core_req = 1; ld_req = 1; ld_lock = 1; ld_we = 1; ld_addr = 32'h8; ld_wdata = 32'h77;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vecs++; if (conflict_cnt !== exp) begin
                errs++; $display("FAIL sat_cnt%0d: got %h want %h", i, conflict_cnt, exp); end
            vecs++; if (ld_gnt !== (i % 2 == 1)) begin
                errs++; $display("FAIL sat_phase%0d: got ld_gnt=%b", i, ld_gnt); end
            if (i % 2 == 0 && exp != 16'hFFFF) exp = exp + 16'd1;
        end
        vecs++; if (conflict_cnt !== 16'hFFFF) begin
            errs++; $display("FAIL sat_final: got %h want ffff", conflict_cnt); end
        cyc(); idle_inputs();
        repeat (2) cyc();
    endtask

    task automatic test_reset_midwrite();
        cyc(); ld_req = 1; ld_we = 1; ld_addr = 32'h20; ld_wdata = 32'h55;
        cyc(); @(negedge clk);
        vecs++; if (ld_gnt !== 1'b1 || mem_we !== 1'b1) begin
            errs++; $display("FAIL rmw_pre: got gnt=%b we=%b want 1/1", ld_gnt, mem_we); end
        #1 clr = 0;
        #1;
        vecs++; if (mem_we !== 1'b0 || ld_gnt !== 1'b0 || mem_addr !== '0) begin
            errs++; $display("FAIL rmw_async: got we=%b gnt=%b a=%h want 0/0/0", mem_we, ld_gnt, mem_addr); end
        vecs++; if (conflict_cnt !== 16'h0) begin errs++; $display("FAIL rmw_cnt: got %h want 0", conflict_cnt); end
        idle_inputs();
        @(negedge clk);
        clr = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vecs++; if ({core_gnt, ld_gnt, core_rvalid, ld_rvalid, mem_we} !== 5'b0) begin
                errs++; $display("FAIL rmw_noretry: got %b want 00000", {core_gnt, ld_gnt, core_rvalid, ld_rvalid, mem_we}); end
        end
        vecs++; if ({core_rdata, ld_rdata} !== '0) begin
            errs++; $display("FAIL rmw_rdata: got %h/%h want 0/0", core_rdata, ld_rdata); end
        vecs++; if (mem[32] === 32'h55) begin errs++; $display("FAIL rmw_mem: got %h want unwritten", mem[32]); end
    endtask

    initial begin
        clr = 1;
        idle_inputs();
        test_reset();
        test_loader_write();
        test_core_write();
        test_core_read();
        test_loader_read();
        test_reset();
        test_tie();
        test_lock();
        test_lock_during_core();
        test_withdraw();
        test_saturation();
        test_reset_midwrite();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish by 200000ns");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits.
REQ-003 CLK  input  1  single clock for all sequential logic, rising edge.
REQ-004 CLR  input  1  reset, asynchronous, active-low; the block SHALL use no other reset.
REQ-005 CORE_REQ, CORE_WE  input  1 each  processor access request and write enable.
REQ-006 CORE_ADDR  input  AW; CORE_WDATA  input  DW  processor address and write data.
REQ-007 CORE_GNT, CORE_RVALID  output  1 each  processor grant and read-data-valid.
REQ-008 CORE_RDATA  output  DW  processor read data.
REQ-009 LD_REQ, LD_WE, LD_LOCK  input  1 each  program-loader request, write enable and bus lock.
REQ-010 LD_ADDR  input  AW; LD_WDATA  input  DW  loader address and write data.
REQ-011 LD_GNT, LD_RVALID  output  1 each; LD_RDATA  output  DW  loader grant, read-data-valid and read data.
REQ-012 MEM_ADDR  output  AW; MEM_WDATA  output  DW; MEM_WE  output  1  shared-memory port.
REQ-013 MEM_RDATA  input  DW  memory read data, valid one cycle after the address is presented.
REQ-014 CORE_STALL  output  1  high while CORE_REQ=1 and the core is not in its grant cycle.
REQ-015 CONFLICT_CNT  output  16  saturating count of tie cycles.

Function
REQ-016 States SHALL be IDLE, GNT_C, GNT_L, RESP_C and RESP_L.
REQ-017 IDLE, CORE_REQ=1 only: next state GNT_C, unless LD_LOCK=1, in which case the state remains IDLE.
REQ-018 IDLE, LD_REQ=1 only: next state GNT_L.
REQ-019 IDLE, both requesting, LD_LOCK=1: next state GNT_L.
REQ-020 IDLE, both requesting, LD_LOCK=0: grant the requester that does not match the LAST owner register (round-robin).
REQ-021 IDLE, both requesting: CONFLICT_CNT SHALL increment by 1 that cycle and hold at 16'hFFFF, with no wrap.
REQ-022 GNT_x SHALL last exactly one cycle; x_GNT=1 throughout.
REQ-023 In GNT_x, MEM_ADDR=x_ADDR, MEM_WDATA=x_WDATA and MEM_WE=x_WE.
REQ-024 In GNT_x, LAST SHALL be updated to x.
REQ-025 GNT_x with x_WE=1: the write SHALL complete in that cycle and the next state SHALL be IDLE (2 cycles from IDLE sample to free).
REQ-026 GNT_x with x_WE=0: next state RESP_x.
REQ-027 In RESP_x, x_RVALID=1 for one cycle, x_RDATA=MEM_RDATA, then next state IDLE (read total 3 cycles).
REQ-028 x_RDATA SHALL be registered on RESP_x exit and hold until the next RESP_x.
REQ-029 Outside GNT states, MEM_WE SHALL be 0 and MEM_ADDR/MEM_WDATA SHALL be 0.
REQ-030 Requesters SHALL hold REQ, WE, ADDR and WDATA stable until x_GNT; the block SHALL sample these only in IDLE and GNT_x.
REQ-031 A REQ deasserted before grant SHALL be treated as withdrawn, with no access issued.
REQ-032 LD_LOCK rising during GNT_C or RESP_C SHALL NOT abort the core access; the lock SHALL take effect at the next IDLE.
REQ-033 At most one of CORE_GNT and LD_GNT SHALL be high in any cycle, and likewise for CORE_RVALID and LD_RVALID.
REQ-034 All outputs except MEM_* and CORE_STALL SHALL be registered or decoded only from state.

Reset
REQ-035 CLR=0 SHALL immediately, without waiting for CLK, force state IDLE and LAST=loader.
REQ-036 CLR=0 SHALL immediately force CONFLICT_CNT=0, x_RDATA=0, and all GNT, RVALID, MEM_WE and MEM_ADDR outputs to 0.
REQ-037 Reset during GNT_x with WE=1 SHALL drop MEM_WE asynchronously; the aborted access SHALL NOT be retried.
REQ-038 After CLR rises, the first IDLE tie with LD_LOCK=0 SHALL grant the core.

Verification
REQ-039 Core read: CORE_REQ=1, WE=0, ADDR=0x10, memory[0x10]=0xDEADBEEF -> CORE_GNT cycle 1, MEM_ADDR=0x10; CORE_RVALID cycle 2, CORE_RDATA=0xDEADBEEF; CORE_STALL=1 in cycle 0 only.
REQ-040 Loader write: LD_REQ=1, WE=1, ADDR=0x4, WDATA=0x00000013 -> single LD_GNT cycle with MEM_WE=1, MEM_WDATA=0x13; no LD_RVALID.
REQ-041 Tie after reset: both requesting reads continuously with LD_LOCK=0 -> grant order core, loader, core, loader; CONFLICT_CNT increments once per arbitration.
REQ-042 Lock: LD_LOCK=1 with both requesting -> only loader grants; CORE_STALL stays 1; core granted first IDLE after LD_LOCK=0.
REQ-043 Saturation: force 70000 tie cycles -> CONFLICT_CNT=0xFFFF, no wrap.
REQ-044 Reset mid-write: CLR=0 asserted mid-cycle in GNT_L with WE=1 -> MEM_WE=0 before next CLK edge; state IDLE and all outputs 0 after reset.
